// File: rtl/nes_controller_emulator_if.sv
// Controller-port pin bundle between a NES console (host) and the emulated pad.
// The console drives latch and clock; the pad drives the active-low serial line.
interface nes_controller_emulator_if;
  logic console_latch_i;
  logic console_clk_i;
  logic console_serial_no;

  modport master (
    output console_latch_i,
    output console_clk_i,
    input  console_serial_no
  );

  modport slave (
    input  console_latch_i,
    input  console_clk_i,
    output console_serial_no
  );
endinterface

// File: rtl/nes_controller_emulator.sv
// Device-side NES controller: synchronises the console latch/clock pins, parallel-loads
// the button word while latch is high, then shifts one active-low bit per console clock.
module nes_controller_emulator #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  buttons_i,
  nes_controller_emulator_if.slave    console,
  output logic                        busy_o,
  output logic                        frame_done_o,
  output logic                        latch_seen_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3
  } state_t;

  logic [SYNC_STAGES-1:0] latch_sync;
  logic [SYNC_STAGES-1:0] cclk_sync;
  logic                   latch_prev;
  logic                   cclk_prev;
  logic                   latch_s;
  logic                   cclk_s;
  logic                   latch_rise;
  logic                   latch_fall;
  logic                   cclk_rise;

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  shift_q;
  logic [7:0]  shift_d;
  logic [3:0]  count_q;
  logic [3:0]  count_d;
  logic        done_d;
  logic        seen_d;

  // Synchronisers plus one extra flop each for edge detection. These are few plain
  // flops, so they get the same synchronous reset as the rest of the state.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      latch_sync <= '0;
      cclk_sync  <= '0;
      latch_prev <= 1'b0;
      cclk_prev  <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], console.console_latch_i};
      cclk_sync  <= {cclk_sync[SYNC_STAGES-2:0], console.console_clk_i};
      latch_prev <= latch_s;
      cclk_prev  <= cclk_s;
    end
  end

  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign cclk_s     = cclk_sync[SYNC_STAGES-1];
  assign latch_rise = latch_s & ~latch_prev;
  assign latch_fall = ~latch_s & latch_prev;
  assign cclk_rise  = cclk_s & ~cclk_prev;

  // Latch always wins over a coincident clock edge, so every branch tests latch_rise first.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    done_d  = 1'b0;
    seen_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (latch_rise) begin
          state_d = LOAD;
          seen_d  = 1'b1;
          shift_d = buttons_i;
        end
      end
      LOAD: begin
        if (latch_s) begin
          shift_d = buttons_i;
        end else if (latch_fall) begin
          state_d = SHIFT;
          count_d = 4'd0;
        end
      end
      SHIFT: begin
        if (latch_rise) begin
          state_d = LOAD;
          seen_d  = 1'b1;
          shift_d = buttons_i;
        end else if (cclk_rise) begin
          shift_d = {shift_q[6:0], 1'b0};
          if (count_q >= 4'd7) begin
            count_d = 4'd8;
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            count_d = count_q + 4'd1;
          end
        end
      end
      DONE: begin
        if (latch_rise) begin
          state_d = LOAD;
          seen_d  = 1'b1;
          shift_d = buttons_i;
        end else if (cclk_rise) begin
          // Keep shifting zeros so the pin stays released, as a real pad does.
          shift_d = {shift_q[6:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      count_q      <= '0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      latch_seen_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      count_q      <= count_d;
      busy_o       <= (state_d == LOAD) || (state_d == SHIFT);
      frame_done_o <= done_d;
      latch_seen_o <= seen_d;
    end
  end

  // shift_q is already a register, so the pin changes one clk after the detected edge.
  assign console.console_serial_no = ~shift_q[7];

endmodule

// File: tb/tb_nes_controller_emulator.sv
// Scoreboard bench for nes_controller_emulator: stimulus pushes expected pin bits and
// pulses into queues; monitors pop and compare when the host samples or the DUT pulses.
module tb_nes_controller_emulator;

  logic       clk;
  logic       rst;
  logic [7:0] buttons;
  logic       busy;
  logic       frame_done;
  logic       latch_seen;

  int errors = 0;
  int checks = 0;

  logic exp_bits[$];
  logic exp_done[$];
  logic exp_seen[$];

  nes_controller_emulator_if nes ();

  nes_controller_emulator #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .buttons_i    (buttons),
    .console      (nes.slave),
    .busy_o       (busy),
    .frame_done_o (frame_done),
    .latch_seen_o (latch_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Host samples the pin just as it raises the console clock.
  always @(posedge nes.console_clk_i) begin
    if (exp_bits.size() != 0) check("serial_bit", {31'd0, nes.console_serial_no}, {31'd0, exp_bits.pop_front()});
  end

  always @(negedge clk) begin
    if (!rst && frame_done) begin
      check("frame_done_expected", {31'd0, exp_done.size() != 0}, 32'd1);
      if (exp_done.size() != 0) void'(exp_done.pop_front());
    end
    if (!rst && latch_seen) begin
      check("latch_seen_expected", {31'd0, exp_seen.size() != 0}, 32'd1);
      if (exp_seen.size() != 0) void'(exp_seen.pop_front());
    end
  end

  task automatic latch_pulse(input logic [7:0] b);
    buttons = b;
    exp_seen.push_back(1'b1);
    nes.console_latch_i = 1'b1;
    #120;
    nes.console_latch_i = 1'b0;
    #100;
  endtask

  // Edges first..first+n-1 of a frame loaded with b; edge 7 completes the frame.
  task automatic shift_bits(input logic [7:0] b, input int first, input int n,
                            input int hi, input int lo);
    for (int i = first; i < first + n; i++) begin
      if (i < 8) exp_bits.push_back(~b[7-i]);
      else       exp_bits.push_back(1'b1);
      if (i == 7) exp_done.push_back(1'b1);
      nes.console_clk_i = 1'b1;
      #hi;
      nes.console_clk_i = 1'b0;
      #lo;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    buttons = 8'h00;
    nes.console_latch_i = 1'b0;
    nes.console_clk_i = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_serial", {31'd0, nes.console_serial_no}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_frame_done", {31'd0, frame_done}, 32'd0);
    check("reset_latch_seen", {31'd0, latch_seen}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a frame aborts it.
    latch_pulse(8'h55);
    check("busy_in_frame", {31'd0, busy}, 32'd1);
    shift_bits(8'h55, 0, 3, 100, 100);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midframe_rst_serial", {31'd0, nes.console_serial_no}, 32'd1);
    check("midframe_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Full frame A5 plus four extra clocks that must read released.
    latch_pulse(8'hA5);
    shift_bits(8'hA5, 0, 8, 100, 100);
    check("busy_after_frame", {31'd0, busy}, 32'd0);
    shift_bits(8'hA5, 8, 4, 100, 100);

    // Buttons changing during SHIFT do not disturb the frame.
    latch_pulse(8'h00);
    shift_bits(8'h00, 0, 2, 100, 100);
    buttons = 8'hFF;
    shift_bits(8'h00, 2, 6, 100, 100);
    latch_pulse(8'hFF);
    shift_bits(8'hFF, 0, 8, 100, 100);

    // Re-latch after three clocks restarts the frame with no frame_done.
    latch_pulse(8'hA5);
    shift_bits(8'hA5, 0, 3, 100, 100);
    latch_pulse(8'h81);
    shift_bits(8'h81, 0, 8, 100, 100);

    // Minimum-width console clock phases: three clk high, three clk low.
    latch_pulse(8'h3C);
    shift_bits(8'h3C, 0, 8, 30, 30);
    #100;
    check("busy_after_minwidth", {31'd0, busy}, 32'd0);

    // Latch and console clock rising together: latch wins.
    latch_pulse(8'h00);
    shift_bits(8'h00, 0, 2, 100, 100);
    buttons = 8'h80;
    exp_seen.push_back(1'b1);
    nes.console_latch_i = 1'b1;
    nes.console_clk_i = 1'b1;
    #60;
    check("coincident_busy", {31'd0, busy}, 32'd1);
    check("coincident_loaded_serial", {31'd0, nes.console_serial_no}, 32'd0);
    nes.console_clk_i = 1'b0;
    #60;
    nes.console_latch_i = 1'b0;
    #100;
    shift_bits(8'h80, 0, 8, 100, 100);

    #300;
    check("bits_queue_empty", exp_bits.size(), 32'd0);
    check("done_queue_empty", exp_done.size(), 32'd0);
    check("seen_queue_empty", exp_seen.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
